// File: rtl/pass_lock_pkg.sv
// Shared FSM state encodings for the password lock controller.
package pass_lock_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StIdle    = 3'd0,
    StEnter   = 3'd1,
    StCheck   = 3'd2,
    StOpen    = 3'd3,
    StFail    = 3'd4,
    StLockout = 3'd5,
    StSetpw   = 3'd6
  } state_e;

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector: one-cycle pulse when d_i goes 0->1 relative to its previous sample.
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Previous-cycle history of the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/pass_lock_ctrl.sv
// Digit-entry password lock with retry limit, timed lockout and code change while open.
module pass_lock_ctrl
  import pass_lock_pkg::*;
#(
  parameter int unsigned               DIGIT_W     = 4,
  parameter int unsigned               N_DIGITS    = 2,
  parameter logic [DIGIT_W*N_DIGITS-1:0] DEFAULT_PW = 8'hA4,
  parameter int unsigned               MAX_TRIES   = 3,
  parameter int unsigned               LOCK_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             confirm,
  input  logic [DIGIT_W-1:0]               pass_data,
  input  logic                             lock_req,
  input  logic                             set_req,
  output logic [StateW-1:0]                state,
  output logic                             unlocked,
  output logic                             alarm,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic [DIGIT_W-1:0]               dout_last,
  output logic [$clog2(N_DIGITS+1)-1:0]    digit_cnt
);

  localparam int unsigned PwW    = DIGIT_W * N_DIGITS;
  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
  localparam int unsigned CntW   = $clog2(N_DIGITS + 1);
  localparam int unsigned TimerW = $clog2(LOCK_CYCLES + 1);

  state_e              state_q, state_d;
  logic [PwW-1:0]      pw_q, pw_d;
  logic [PwW-1:0]      buf_q, buf_d, buf_wr;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [TriesW-1:0]   tries_q, tries_d;
  logic [DIGIT_W-1:0]  dout_q, dout_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                unlocked_q, unlocked_d;
  logic                alarm_q, alarm_d;
  logic                rise;
  logic                last_digit;

  edge_detect_rise u_confirm_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (confirm),
    .rise_o (rise)
  );

  // Entry buffer with the incoming digit written into slot cnt_q (slot 0 in the MSBs).
  always_comb begin
    buf_wr = buf_q;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (cnt_q == CntW'(i)) begin
        buf_wr[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = pass_data;
      end
    end
  end

  assign last_digit = (cnt_q == CntW'(N_DIGITS - 1));

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    dout_d  = dout_q;
    timer_d = timer_q;
    unique case (state_q)
      StIdle, StEnter: begin
        if (rise) begin
          buf_d   = buf_wr;
          dout_d  = pass_data;
          cnt_d   = cnt_q + 1'b1;
          state_d = last_digit ? StCheck : StEnter;
        end
      end
      StCheck: begin
        if (buf_q == pw_q) begin
          state_d = StOpen;
          tries_d = TriesW'(MAX_TRIES);
          cnt_d   = '0;
          buf_d   = '0;
        end else begin
          tries_d = tries_q - 1'b1;
          if (tries_q <= TriesW'(1)) begin
            state_d = StLockout;
            timer_d = TimerW'(LOCK_CYCLES);
          end else begin
            state_d = StFail;
          end
        end
      end
      StFail: begin
        state_d = StIdle;
        cnt_d   = '0;
        buf_d   = '0;
      end
      StOpen: begin
        // lock_req takes priority over set_req.
        if (lock_req) begin
          state_d = StIdle;
          cnt_d   = '0;
          buf_d   = '0;
        end else if (set_req) begin
          state_d = StSetpw;
          cnt_d   = '0;
          buf_d   = '0;
        end
      end
      StSetpw: begin
        if (lock_req) begin
          state_d = StIdle;
          cnt_d   = '0;
          buf_d   = '0;
        end else if (rise) begin
          dout_d = pass_data;
          if (last_digit) begin
            pw_d    = buf_wr;
            state_d = StOpen;
            cnt_d   = '0;
            buf_d   = '0;
          end else begin
            buf_d = buf_wr;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StLockout: begin
        if (timer_q <= TimerW'(1)) begin
          state_d = StIdle;
          tries_d = TriesW'(MAX_TRIES);
          timer_d = '0;
          cnt_d   = '0;
          buf_d   = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        buf_d   = '0;
      end
    endcase
    unlocked_d = (state_d == StOpen);
    alarm_d    = (state_d == StLockout);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pw_q       <= DEFAULT_PW;
      buf_q      <= '0;
      cnt_q      <= '0;
      tries_q    <= TriesW'(MAX_TRIES);
      dout_q     <= '0;
      timer_q    <= '0;
      unlocked_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pw_q       <= pw_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      tries_q    <= tries_d;
      dout_q     <= dout_d;
      timer_q    <= timer_d;
      unlocked_q <= unlocked_d;
      alarm_q    <= alarm_d;
    end
  end

  assign state      = state_q;
  assign unlocked   = unlocked_q;
  assign alarm      = alarm_q;
  assign tries_left = tries_q;
  assign dout_last  = dout_q;
  assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_pass_lock_ctrl.sv
// Self-checking bench for pass_lock_ctrl: vector table, directed corner sequences, random vs model.
module tb_pass_lock_ctrl;

  localparam int S_IDLE = 0, S_ENTER = 1, S_CHECK = 2, S_OPEN = 3;
  localparam int S_FAIL = 4, S_LOCK = 5, S_SETPW = 6;
  localparam int NDIG = 2, MAXT = 3, LOCKC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       confirm = 1'b0;
  logic [3:0] pass_data = 4'h0;
  logic       lock_req = 1'b0;
  logic       set_req = 1'b0;
  logic [2:0] state;
  logic       unlocked, alarm;
  logic [1:0] tries_left;
  logic [3:0] dout_last;
  logic [1:0] digit_cnt;

  int vectors = 0;
  int miscompares = 0;

  pass_lock_ctrl #(
    .DIGIT_W     (4),
    .N_DIGITS    (2),
    .DEFAULT_PW  (8'hA4),
    .MAX_TRIES   (3),
    .LOCK_CYCLES (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .confirm    (confirm),
    .pass_data  (pass_data),
    .lock_req   (lock_req),
    .set_req    (set_req),
    .state      (state),
    .unlocked   (unlocked),
    .alarm      (alarm),
    .tries_left (tries_left),
    .dout_last  (dout_last),
    .digit_cnt  (digit_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: entry kept as a queue of digits, code as a digit array.
  int         m_state = S_IDLE;
  int         m_tries = MAXT;
  int         m_timer = 0;
  bit         m_prev = 1'b0;
  logic [3:0] m_dout = 4'h0;
  int         m_entry[$];
  int         m_code[NDIG];

  function automatic void model_reset();
    m_state = S_IDLE;
    m_tries = MAXT;
    m_timer = 0;
    m_prev  = 1'b0;
    m_dout  = 4'h0;
    m_entry.delete();
    m_code[0] = 'hA;
    m_code[1] = 'h4;
  endfunction

  function automatic bit entry_matches();
    for (int i = 0; i < NDIG; i++) if (m_entry[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_step(bit r, bit c, logic [3:0] d, bit l, bit s);
    bit rise;
    rise   = c && !m_prev;
    m_prev = c;
    if (r) begin
      model_reset();
      return;
    end
    case (m_state)
      S_IDLE, S_ENTER: if (rise) begin
        m_entry.push_back(int'(d));
        m_dout  = d;
        m_state = (m_entry.size() == NDIG) ? S_CHECK : S_ENTER;
      end
      S_CHECK: begin
        if (entry_matches()) begin
          m_state = S_OPEN;
          m_tries = MAXT;
          m_entry.delete();
        end else begin
          m_tries--;
          if (m_tries == 0) begin
            m_state = S_LOCK;
            m_timer = LOCKC;
          end else begin
            m_state = S_FAIL;
          end
        end
      end
      S_FAIL: begin
        m_state = S_IDLE;
        m_entry.delete();
      end
      S_OPEN: begin
        if (l) begin
          m_state = S_IDLE;
          m_entry.delete();
        end else if (s) begin
          m_state = S_SETPW;
          m_entry.delete();
        end
      end
      S_SETPW: begin
        if (l) begin
          m_state = S_IDLE;
          m_entry.delete();
        end else if (rise) begin
          m_entry.push_back(int'(d));
          m_dout = d;
          if (m_entry.size() == NDIG) begin
            for (int i = 0; i < NDIG; i++) m_code[i] = m_entry[i];
            m_entry.delete();
            m_state = S_OPEN;
          end
        end
      end
      S_LOCK: begin
        m_timer--;
        if (m_timer == 0) begin
          m_state = S_IDLE;
          m_tries = MAXT;
          m_entry.delete();
        end
      end
      default: m_state = S_IDLE;
    endcase
  endfunction

  task automatic check_model(input string name);
    vectors++;
    if (state !== 3'(m_state) || unlocked !== (m_state == S_OPEN) || alarm !== (m_state == S_LOCK)
        || tries_left !== 2'(m_tries) || dout_last !== m_dout
        || digit_cnt !== 2'(m_entry.size())) begin
      miscompares++;
      $display("FAIL %s t=%0t: got st=%0d unl=%b alm=%b tries=%0d dout=%h cnt=%0d, want st=%0d tries=%0d dout=%h cnt=%0d",
               name, $time, state, unlocked, alarm, tries_left, dout_last, digit_cnt,
               m_state, m_tries, m_dout, m_entry.size());
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, and compare after the edge.
  task automatic step(input bit r, input bit c, input logic [3:0] d, input bit l, input bit s);
    rst = r; confirm = c; pass_data = d; lock_req = l; set_req = s;
    @(posedge clk);
    model_step(r, c, d, l, s);
    #1;
    check_model("model");
  endtask

  task automatic enter_code(input logic [3:0] a, input logic [3:0] b);
    step(0, 1, a, 0, 0);
    step(0, 0, a, 0, 0);
    step(0, 1, b, 0, 0);
    step(0, 0, b, 0, 0);
  endtask

  typedef struct {
    bit         r, c, l, s;
    logic [3:0] d;
    logic [2:0] e_state;
    logic [1:0] e_tries;
    logic [3:0] e_dout;
    logic [1:0] e_cnt;
    bit         e_unl;
  } vec_t;

  vec_t tbl[11];
  int   n;

  initial begin
    //            r  c  l  s  d     state    tries dout  cnt unl
    tbl[0]  = '{1, 0, 0, 0, 4'h0, 3'd0,   2'd3, 4'h0, 2'd0, 0};
    tbl[1]  = '{0, 1, 0, 0, 4'hA, 3'd1,   2'd3, 4'hA, 2'd1, 0};
    tbl[2]  = '{0, 0, 0, 0, 4'hA, 3'd1,   2'd3, 4'hA, 2'd1, 0};
    tbl[3]  = '{0, 1, 0, 0, 4'h4, 3'd2,   2'd3, 4'h4, 2'd2, 0};
    tbl[4]  = '{0, 0, 0, 0, 4'h4, 3'd3,   2'd3, 4'h4, 2'd0, 1};
    tbl[5]  = '{0, 0, 1, 0, 4'h4, 3'd0,   2'd3, 4'h4, 2'd0, 0};
    tbl[6]  = '{0, 1, 0, 0, 4'hA, 3'd1,   2'd3, 4'hA, 2'd1, 0};
    tbl[7]  = '{0, 0, 0, 0, 4'hA, 3'd1,   2'd3, 4'hA, 2'd1, 0};
    tbl[8]  = '{0, 1, 0, 0, 4'h3, 3'd2,   2'd3, 4'h3, 2'd2, 0};
    tbl[9]  = '{0, 0, 0, 0, 4'h3, 3'd4,   2'd2, 4'h3, 2'd2, 0};
    tbl[10] = '{0, 0, 0, 0, 4'h3, 3'd0,   2'd2, 4'h3, 2'd0, 0};

    model_reset();
    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].c, tbl[i].d, tbl[i].l, tbl[i].s);
      vectors++;
      if (state !== tbl[i].e_state || tries_left !== tbl[i].e_tries || dout_last !== tbl[i].e_dout
          || digit_cnt !== tbl[i].e_cnt || unlocked !== tbl[i].e_unl) begin
        miscompares++;
        $display("FAIL table[%0d]: got st=%0d tries=%0d dout=%h cnt=%0d unl=%b want st=%0d tries=%0d dout=%h cnt=%0d unl=%b",
                 i, state, tries_left, dout_last, digit_cnt, unlocked, tbl[i].e_state,
                 tbl[i].e_tries, tbl[i].e_dout, tbl[i].e_cnt, tbl[i].e_unl);
      end
    end

    // Three wrong codes -> timed lockout that ignores confirm.
    step(1, 0, 4'h0, 0, 0);
    enter_code(4'h1, 4'h1); step(0, 0, 4'h0, 0, 0);
    enter_code(4'h2, 4'h2); step(0, 0, 4'h0, 0, 0);
    enter_code(4'h3, 4'h3);
    check_val("lock_state", 32'(state), 32'd5);
    check_val("lock_alarm", 32'(alarm), 32'd1);
    check_val("lock_tries", 32'(tries_left), 32'd0);
    n = 0;
    while (alarm === 1'b1 && n < 40) begin
      n++;
      step(0, n[0], 4'h9, 0, 0);
    end
    check_val("lock_cycles", 32'(n), 32'd16);
    check_val("lock_exit_state", 32'(state), 32'd0);
    check_val("lock_exit_tries", 32'(tries_left), 32'd3);
    check_val("lock_dout_kept", 32'(dout_last), 32'h3);
    check_val("lock_cnt", 32'(digit_cnt), 32'd0);
    step(0, 0, 4'h0, 0, 0);

    // Change code while open, abort with lock, old code rejected, new code accepted.
    step(1, 0, 4'h0, 0, 0);
    enter_code(4'hA, 4'h4);
    check_val("open_unl", 32'(unlocked), 32'd1);
    step(0, 0, 4'h0, 0, 1);
    check_val("setpw_state", 32'(state), 32'd6);
    step(0, 1, 4'h5, 0, 0); step(0, 0, 4'h5, 0, 0); step(0, 1, 4'h6, 0, 0);
    check_val("setpw_commit_state", 32'(state), 32'd3);
    check_val("setpw_dout", 32'(dout_last), 32'h6);
    step(0, 0, 4'h0, 0, 0);
    step(0, 0, 4'h0, 1, 0);
    check_val("relock_state", 32'(state), 32'd0);
    enter_code(4'hA, 4'h4);
    check_val("old_code_fail", 32'(state), 32'd4);
    step(0, 0, 4'h0, 0, 0);
    enter_code(4'h5, 4'h6);
    check_val("new_code_open", 32'(state), 32'd3);

    // Held confirm accepts one digit; lock beats set in OPEN.
    step(1, 0, 4'h0, 0, 0);
    for (int i = 0; i < 40; i++) step(0, 1, 4'h7, 0, 0);
    check_val("held_cnt", 32'(digit_cnt), 32'd1);
    check_val("held_dout", 32'(dout_last), 32'h7);
    step(1, 0, 4'h0, 0, 0);
    enter_code(4'hA, 4'h4);
    step(0, 0, 4'h0, 1, 1);
    check_val("lock_wins_state", 32'(state), 32'd0);

    // Reset mid-entry discards the partial code.
    step(0, 1, 4'hA, 0, 0);
    step(1, 1, 4'hA, 0, 0);
    check_val("rst_mid_cnt", 32'(digit_cnt), 32'd0);
    check_val("rst_mid_state", 32'(state), 32'd0);
    step(0, 0, 4'h0, 0, 0);
    enter_code(4'hA, 4'h4);
    check_val("rst_then_open", 32'(state), 32'd3);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      int         p;
      logic [3:0] d;
      p = int'($urandom_range(0, 9));
      d = (p < 4) ? 4'hA : (p < 8) ? 4'h4 : 4'($urandom);
      step(($urandom_range(0, 199) == 0), 1'($urandom), d,
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
